// File: rtl/btb_pkg.sv
// Shared widths, update record and controller state encoding for the BTB update path.
package btb_pkg;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned TAG_W = 27;
  localparam int unsigned TGT_W = 32;

  typedef logic way_t;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] target;
    logic             taken;
  } btb_upd_t;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StCmp,
    StWr
  } ctrl_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO of pending BTB updates; Depth must be a power of two (>= 2).
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     push,
  input  btb_upd_t wdata,
  input  logic     pop,
  output btb_upd_t rdata,
  output logic     full,
  output logic     empty,
  output logic     single
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  btb_upd_t        mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wptr_q[AddrW-1:0]] <= wdata;
  end

  // Extra pointer bit distinguishes full from empty when the address bits match.
  assign count  = wptr_q - rptr_q;
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]) && (wptr_q[AddrW] != rptr_q[AddrW]);
  assign single = (count == PtrW'(1));
  assign rdata  = mem_q[rptr_q[AddrW-1:0]];

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequences EX branch-resolution updates into the 2-way BTB: read tags, pick a way, then write
// on the shared port, yielding to IF lookups until the starvation guard forces the write.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned QDEPTH    = 2,
  parameter int unsigned STALL_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [TGT_W-1:0] upd_target,
  input  logic             upd_taken,
  input  logic             flush,
  input  logic             if_read_active,
  output logic             tag_rd_en,
  output logic [IDX_W-1:0] tag_rd_index,
  input  logic             way0_valid,
  input  logic [TAG_W-1:0] way0_tag,
  input  logic             way1_valid,
  input  logic [TAG_W-1:0] way1_tag,
  input  logic             lru_bit,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_index,
  output logic             wr_way,
  output logic             wr_valid,
  output logic [TAG_W-1:0] wr_tag,
  output logic [TGT_W-1:0] wr_target,
  output logic             lru_touch,
  output logic             lru_touch_way,
  output logic             if_hold,
  output logic             busy
);

  localparam int unsigned        StallW   = $clog2(STALL_MAX + 1);
  localparam logic [StallW-1:0] StallMax = StallW'(STALL_MAX);

  ctrl_state_e       state_q, state_d;
  logic [StallW-1:0] stall_q, stall_d;
  way_t              lru_q, lru_d;
  way_t              way_q, way_d;
  logic              wvalid_q, wvalid_d;

  btb_upd_t in_upd, head;
  logic     full, empty, single;
  logic     push, pop;
  logic     hit0, hit1, forced, issue, more;

  // A full FIFO refuses new work even when the head pops in the same cycle.
  assign upd_ready = !full;
  assign push      = upd_valid && !full && !flush;
  assign in_upd    = '{index: upd_index, tag: upd_tag, target: upd_target, taken: upd_taken};
  assign busy      = (state_q != StIdle) || !empty;

  btb_upd_fifo #(
    .Depth(QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .wdata (in_upd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .single(single)
  );

  assign hit0   = way0_valid && (way0_tag == head.tag);
  assign hit1   = way1_valid && (way1_tag == head.tag);
  assign forced = (stall_q == StallMax);
  assign issue  = (state_q == StWr) && (!if_read_active || forced) && !flush;
  // Work remains after popping the head if another entry is queued or one arrives now.
  assign more   = !single || push;

  always_comb begin
    state_d       = state_q;
    stall_d       = stall_q;
    lru_d         = lru_q;
    way_d         = way_q;
    wvalid_d      = wvalid_q;
    pop           = 1'b0;
    tag_rd_en     = 1'b0;
    tag_rd_index  = '0;
    wr_en         = 1'b0;
    wr_index      = '0;
    wr_way        = 1'b0;
    wr_valid      = 1'b0;
    wr_tag        = '0;
    wr_target     = '0;
    lru_touch     = 1'b0;
    lru_touch_way = 1'b0;
    if_hold       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty || push) state_d = StRd;
      end
      StRd: begin
        tag_rd_en    = 1'b1;
        tag_rd_index = head.index;
        lru_d        = lru_bit;
        state_d      = StCmp;
      end
      StCmp: begin
        state_d = StWr;
        if (head.taken) begin
          wvalid_d = 1'b1;
          if (hit0)             way_d = 1'b0;
          else if (hit1)        way_d = 1'b1;
          else if (!way0_valid) way_d = 1'b0;
          else if (!way1_valid) way_d = 1'b1;
          else                  way_d = ~lru_q;
        end else if (hit0 || hit1) begin
          wvalid_d = 1'b0;
          way_d    = hit0 ? 1'b0 : 1'b1;
        end else begin
          pop     = 1'b1;
          state_d = more ? StRd : StIdle;
        end
      end
      StWr: begin
        if (issue) begin
          wr_en         = 1'b1;
          wr_index      = head.index;
          wr_way        = way_q;
          wr_valid      = wvalid_q;
          wr_tag        = head.tag;
          wr_target     = head.target;
          lru_touch     = wvalid_q;
          lru_touch_way = way_q;
          if_hold       = if_read_active && forced;
          pop           = 1'b1;
          stall_d       = '0;
          state_d       = more ? StRd : StIdle;
        end else if (!forced) begin
          stall_d = stall_q + StallW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d   = StIdle;
      stall_d   = '0;
      pop       = 1'b0;
      tag_rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      stall_q  <= '0;
      lru_q    <= 1'b0;
      way_q    <= 1'b0;
      wvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      lru_q    <= lru_d;
      way_q    <= way_d;
      wvalid_q <= wvalid_d;
    end
  end

endmodule
